// File: rtl/risc16_mc_core.sv
// Multi-cycle RiSC-16 core: BOOT/FETCH/DECODE/EXEC/MEM/HALT sequencing with
// req/ack instruction and data ports and a registered one-cycle retire trace.
module risc16_mc_core #(
  parameter int unsigned             XLEN     = 16,
  parameter int unsigned             ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              halted,
  output logic              retire_valid,
  output logic [ADDR_W-1:0] retire_pc,
  output logic              retire_wen,
  output logic [2:0]        retire_rd,
  output logic [XLEN-1:0]   retire_wdata
);

  typedef enum logic [2:0] {
    ST_BOOT, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD, OP_ADDI, OP_NAND, OP_LUI, OP_SW, OP_LW, OP_BEQ, OP_JALR
  } opcode_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [XLEN-1:0]     ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic                dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0]     dmem_wdata_q, dmem_wdata_d;
  logic                ret_valid_q, ret_valid_d;
  logic [ADDR_W-1:0]   ret_pc_q, ret_pc_d;
  logic                ret_wen_q, ret_wen_d;
  logic [2:0]          ret_rd_q, ret_rd_d;
  logic [XLEN-1:0]     ret_wdata_q, ret_wdata_d;
  logic [XLEN-1:0]     rf_q [8];

  logic                rf_we;
  logic [XLEN-1:0]     rf_wdata;
  logic                commit;
  logic                wr_en;
  logic [XLEN-1:0]     wr_data;

  opcode_e             opcode;
  logic [2:0]          fa, fb, fc;
  logic [XLEN-1:0]     simm, imm_hi, ea;
  logic [ADDR_W-1:0]   pc_inc, br_tgt;

  assign opcode = opcode_e'(ir_q[15:13]);
  assign fa     = ir_q[12:10];
  assign fb     = ir_q[9:7];
  assign fc     = ir_q[2:0];
  assign simm   = {{(XLEN-7){ir_q[6]}}, ir_q[6:0]};
  assign imm_hi = {ir_q[9:0], {(XLEN-10){1'b0}}};
  assign ea     = rb_q + simm;
  assign pc_inc = pc_q + ADDR_W'(1);
  assign br_tgt = pc_inc + simm[ADDR_W-1:0];

  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    rc_d         = rc_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    commit       = 1'b0;
    wr_en        = 1'b0;
    wr_data      = '0;

    unique case (state_q)
      ST_BOOT:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ra_d    = rf_q[fa];
        rb_d    = rf_q[fb];
        rc_d    = rf_q[fc];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        commit  = 1'b1;
        pc_d    = pc_inc;
        unique case (opcode)
          OP_ADD:  begin wr_en = 1'b1; wr_data = rb_q + rc_q;    end
          OP_ADDI: begin wr_en = 1'b1; wr_data = rb_q + simm;    end
          OP_NAND: begin wr_en = 1'b1; wr_data = ~(rb_q & rc_q); end
          OP_LUI:  begin wr_en = 1'b1; wr_data = imm_hi;         end
          OP_SW, OP_LW: begin
            commit       = 1'b0;
            pc_d         = pc_q;
            state_d      = ST_MEM;
            dmem_addr_d  = ea[ADDR_W-1:0];
            dmem_we_d    = (opcode == OP_SW);
            dmem_wdata_d = (opcode == OP_SW) ? ra_q : '0;
          end
          OP_BEQ: begin
            if (ra_q == rb_q) pc_d = br_tgt;
          end
          OP_JALR: begin
            if (ir_q[6:0] == 7'd0) begin
              wr_en   = 1'b1;
              wr_data = XLEN'(pc_inc);
              pc_d    = rb_q[ADDR_W-1:0];
            end else begin
              commit  = 1'b0;
              pc_d    = pc_q;
              state_d = ST_HALT;
            end
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          commit  = 1'b1;
          pc_d    = pc_inc;
          state_d = ST_FETCH;
          if (!dmem_we_q) begin
            wr_en   = 1'b1;
            wr_data = dmem_rdata;
          end
        end
      end
      ST_HALT:  ;
      default:  state_d = ST_BOOT;
    endcase

    // Writes to R0 are dropped here, so R0 keeps its reset value of zero.
    rf_we       = wr_en && (fa != 3'd0);
    rf_wdata    = wr_data;
    ret_valid_d = commit;
    ret_pc_d    = commit ? pc_q : '0;
    ret_wen_d   = rf_we;
    ret_rd_d    = wr_en ? fa : 3'd0;
    ret_wdata_d = wr_en ? wr_data : '0;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // values computed before this edge, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      rc_q         <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      ret_valid_q  <= 1'b0;
      ret_pc_q     <= '0;
      ret_wen_q    <= 1'b0;
      ret_rd_q     <= '0;
      ret_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      rc_q         <= rc_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      ret_valid_q  <= ret_valid_d;
      ret_pc_q     <= ret_pc_d;
      ret_wen_q    <= ret_wen_d;
      ret_rd_q     <= ret_rd_d;
      ret_wdata_q  <= ret_wdata_d;
    end
  end

  // NOTE: the register file is reset because the architecture defines all
  // registers as zero after reset; it is only eight words, so flops are fine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[fa] <= rf_wdata;
    end
  end

  assign imem_req     = (state_q == ST_FETCH);
  assign imem_addr    = pc_q;
  assign dmem_req     = (state_q == ST_MEM);
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign halted       = (state_q == ST_HALT);
  assign retire_valid = ret_valid_q;
  assign retire_pc    = ret_pc_q;
  assign retire_wen   = ret_wen_q;
  assign retire_rd    = ret_rd_q;
  assign retire_wdata = ret_wdata_q;

endmodule

// File: tb/tb_risc16_mc_core.sv
// Directed bench for risc16_mc_core: small instruction/data memory models with
// programmable wait states and hand-computed retire-trace expectations.
module tb_risc16_mc_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        halted, retire_valid, retire_wen;
  logic [15:0] retire_pc, retire_wdata;
  logic [2:0]  retire_rd;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  int          iwait = 0, dwait = 0;
  int          icnt, dcnt;
  int          cyc = 0;
  int          t_prev = 0;
  int          n_checks = 0, n_fail = 0;

  risc16_mc_core #(.XLEN(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .halted(halted), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_wen(retire_wen), .retire_rd(retire_rd), .retire_wdata(retire_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memories: combinational read, ack after iwait/dwait stalled cycles.
  assign imem_rdata = imem[imem_addr[7:0]];
  assign dmem_rdata = dmem[dmem_addr[7:0]];
  assign imem_ack   = imem_req && (icnt >= iwait);
  assign dmem_ack   = dmem_req && (dcnt >= dwait);

  always @(posedge clk or posedge rst) begin
    if (rst)                       icnt <= 0;
    else if (imem_req && !imem_ack) icnt <= icnt + 1;
    else                           icnt <= 0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst)                       dcnt <= 0;
    else if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
    else                           dcnt <= 0;
  end

  always @(posedge clk) begin
    if (!rst && dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[7:0]] <= dmem_wdata;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic [2:0] c);
    return {op, a, b, 4'b0000, c};
  endfunction

  function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input int imm);
    logic [6:0] i7;
    i7 = 7'(imm);
    return {op, a, b, i7};
  endfunction

  function automatic logic [15:0] lui(input logic [2:0] a, input logic [9:0] imm);
    return {3'b011, a, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  // Reset for 3 cycles, release, then step to the first FETCH cycle.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    t_prev = cyc;
  endtask

  task automatic expect_retire(input string tag, input int pc, input bit wen,
                               input bit chk_data, input int rd, input int wdata,
                               input int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!retire_valid && n < 100);
    check({tag, ".valid"}, 32'(retire_valid), 32'd1);
    check({tag, ".pc"},    32'(retire_pc),    32'(pc));
    check({tag, ".wen"},   32'(retire_wen),   32'(wen));
    if (chk_data) begin
      check({tag, ".rd"},    32'(retire_rd),    32'(rd));
      check({tag, ".wdata"}, 32'(retire_wdata), 32'(wdata));
    end
    if (lat > 0) check({tag, ".latency"}, 32'(cyc - t_prev), 32'(lat));
    t_prev = cyc;
  endtask

  initial begin
    int n;
    int act;
    rst = 1'b1;
    for (int i = 0; i < 256; i++) dmem[i] = 16'h0000;
    dmem[2] = 16'hAAAA;

    // ---------------- Program 1: ALU chain, memory with waits, R0, halt
    clear_imem();
    imem[0]  = rri(3'b001, 3'd1, 3'd0, 5);
    imem[1]  = rri(3'b001, 3'd2, 3'd0, -3);
    imem[2]  = rrr(3'b000, 3'd3, 3'd1, 3'd2);
    imem[3]  = rrr(3'b010, 3'd4, 3'd3, 3'd3);
    imem[4]  = lui(3'd5, 10'h3FF);
    imem[5]  = rri(3'b100, 3'd1, 3'd0, 2);
    imem[6]  = rri(3'b101, 3'd6, 3'd0, 2);
    imem[7]  = rri(3'b001, 3'd0, 3'd0, 7);
    imem[8]  = rrr(3'b000, 3'd6, 3'd0, 3'd0);
    imem[9]  = rri(3'b001, 3'd7, 3'd0, -1);
    imem[10] = rri(3'b001, 3'd2, 3'd0, 1);
    imem[11] = rrr(3'b000, 3'd3, 3'd7, 3'd2);
    imem[12] = rri(3'b111, 3'd0, 3'd0, 1);

    repeat (3) @(negedge clk);
    check("rst.imem_req",     32'(imem_req),     32'd0);
    check("rst.imem_addr",    32'(imem_addr),    32'd0);
    check("rst.dmem_req",     32'(dmem_req),     32'd0);
    check("rst.halted",       32'(halted),       32'd0);
    check("rst.retire_valid", 32'(retire_valid), 32'd0);
    check("rst.retire_wen",   32'(retire_wen),   32'd0);
    check("rst.retire_wdata", 32'(retire_wdata), 32'd0);
    rst = 1'b0;
    #1;
    check("boot.imem_req_low", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("boot.imem_req_high", 32'(imem_req),  32'd1);
    check("boot.imem_addr",     32'(imem_addr), 32'd0);
    check("boot.retire_valid",  32'(retire_valid), 32'd0);
    t_prev = cyc;
    dwait = 2;

    expect_retire("addi_r1", 0, 1, 1, 1, 16'h0005, 3);
    expect_retire("addi_r2", 1, 1, 1, 2, 16'hFFFD, 3);
    expect_retire("add_r3",  2, 1, 1, 3, 16'h0002, 3);
    expect_retire("nand_r4", 3, 1, 1, 4, 16'hFFFD, 3);
    expect_retire("lui_r5",  4, 1, 1, 5, 16'hFFC0, 3);

    n = 0;
    while (!dmem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sw.req",   32'(dmem_req),   32'd1);
    check("sw.we",    32'(dmem_we),    32'd1);
    check("sw.addr",  32'(dmem_addr),  32'd2);
    check("sw.wdata", 32'(dmem_wdata), 32'd5);
    @(negedge clk);
    check("sw.req_held",   32'(dmem_req),   32'd1);
    check("sw.addr_held",  32'(dmem_addr),  32'd2);
    check("sw.wdata_held", 32'(dmem_wdata), 32'd5);
    expect_retire("sw", 5, 0, 0, 0, 0, 6);
    check("sw.mem", 32'(dmem[2]), 32'd5);
    expect_retire("lw_r6",   6, 1, 1, 6, 16'h0005, 6);
    expect_retire("addi_r0", 7, 0, 0, 0, 0, 3);
    expect_retire("r0_read", 8, 1, 1, 6, 16'h0000, 3);
    expect_retire("addi_r7", 9, 1, 1, 7, 16'hFFFF, 3);
    expect_retire("addi_r2b", 10, 1, 1, 2, 16'h0001, 3);
    expect_retire("add_wrap", 11, 1, 1, 3, 16'h0000, 3);

    repeat (2) @(negedge clk);
    check("halt.not_yet", 32'(halted), 32'd0);
    @(negedge clk);
    check("halt.halted", 32'(halted),    32'd1);
    check("halt.pc",     32'(imem_addr), 32'd12);
    act = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req || dmem_req || retire_valid || !halted) act++;
    end
    check("halt.quiet",   32'(act),       32'd0);
    check("halt.pc_held", 32'(imem_addr), 32'd12);

    // ---------------- Program 2: taken BEQ loop at PC 10
    dwait = 0;
    clear_imem();
    imem[0]  = rri(3'b001, 3'd1, 3'd0, 5);
    imem[1]  = rri(3'b110, 3'd0, 3'd0, 8);
    imem[10] = rri(3'b110, 3'd1, 3'd1, -1);
    do_reset();
    check("p2.halted_cleared", 32'(halted), 32'd0);
    expect_retire("p2.addi", 0, 1, 1, 1, 16'h0005, 3);
    expect_retire("p2.beq_jump", 1, 0, 0, 0, 0, 3);
    check("p2.fetch10", 32'(imem_addr), 32'd10);
    expect_retire("p2.beq_loop1", 10, 0, 0, 0, 0, 3);
    check("p2.loop_fetch1", 32'(imem_addr), 32'd10);
    expect_retire("p2.beq_loop2", 10, 0, 0, 0, 0, 3);
    check("p2.loop_fetch2", 32'(imem_addr), 32'd10);

    // ---------------- Program 3: fetch wait state, not-taken BEQ, JALR
    iwait = 1;
    clear_imem();
    imem[0]  = rrr(3'b000, 3'd4, 3'd1, 3'd0);
    imem[1]  = rri(3'b001, 3'd1, 3'd0, 5);
    imem[2]  = rri(3'b001, 3'd2, 3'd0, -3);
    imem[3]  = rri(3'b001, 3'd3, 3'd0, 2);
    imem[4]  = rri(3'b110, 3'd0, 3'd0, 5);
    imem[10] = rri(3'b110, 3'd1, 3'd2, 3);
    imem[11] = rri(3'b110, 3'd0, 3'd0, 8);
    imem[20] = rri(3'b111, 3'd7, 3'd3, 0);
    do_reset();
    expect_retire("p3.rf_reset", 0, 1, 1, 4, 16'h0000, 4);
    expect_retire("p3.addi_r1", 1, 1, 1, 1, 16'h0005, 4);
    expect_retire("p3.addi_r2", 2, 1, 1, 2, 16'hFFFD, 4);
    expect_retire("p3.addi_r3", 3, 1, 1, 3, 16'h0002, 4);
    expect_retire("p3.beq_to10", 4, 0, 0, 0, 0, 4);
    expect_retire("p3.beq_nt", 10, 0, 0, 0, 0, 4);
    check("p3.fetch11", 32'(imem_addr), 32'd11);
    expect_retire("p3.beq_to20", 11, 0, 0, 0, 0, 4);
    check("p3.fetch20", 32'(imem_addr), 32'd20);
    expect_retire("p3.jalr", 20, 1, 1, 7, 16'h0015, 4);
    check("p3.fetch_target", 32'(imem_addr), 32'd2);
    expect_retire("p3.after_jalr", 2, 1, 1, 2, 16'hFFFD, 4);

    // ---------------- Program 4: reset while a store is pending
    iwait = 0;
    dwait = 100;
    dmem[3] = 16'h1234;
    clear_imem();
    imem[0] = rri(3'b001, 3'd1, 3'd0, 5);
    imem[1] = rri(3'b100, 3'd1, 3'd0, 3);
    do_reset();
    expect_retire("p4.addi", 0, 1, 1, 1, 16'h0005, 3);
    n = 0;
    while (!dmem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("p4.req_pending", 32'(dmem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("p4.req_dropped", 32'(dmem_req),  32'd0);
    check("p4.pc_reset",    32'(imem_addr), 32'd0);
    repeat (2) @(negedge clk);
    dwait = 0;
    rst = 1'b0;
    check("p4.store_aborted", 32'(dmem[3]), 32'h1234);
    @(negedge clk);
    check("p4.reboot_req",  32'(imem_req),  32'd1);
    check("p4.reboot_addr", 32'(imem_addr), 32'd0);
    t_prev = cyc;
    expect_retire("p4.addi_again", 0, 1, 1, 1, 16'h0005, 3);
    expect_retire("p4.sw", 1, 0, 0, 0, 0, 4);
    check("p4.store_done", 32'(dmem[3]), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
